geo_ram_seq: RTL and testbench

GEO_RAM_SEQ -- requirements
Module: geo_ram_seq

---
 rtl/geo_ram_seq.sv | 141 ++++++++++++++
 tb/tb_geo_ram_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/geo_ram_seq.sv
// GeoRAM-style sequencer: power-up init burst, then C64 window accesses with
// opportunistic refresh, plus a fixed one-cycle read-return path.
module geo_ram_seq #(
    parameter int REFDIV  = 15,
    parameter int INITCYC = 100
) (
    input  logic        PHI2,
    input  logic        nRESET,
    input  logic        RamSEL,
    input  logic        nWE,
    input  logic [7:0]  A,
    input  logic [7:0]  WRD,
    input  logic [7:0]  Block,
    input  logic [5:0]  Window,
    input  logic [7:0]  RDQ,
    output logic [21:0] RA,
    output logic [1:0]  RCMD,
    output logic [7:0]  RWD,
    output logic [7:0]  RDD,
    output logic        RDV,
    output logic        Ready,
    output logic        RefOvf
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    localparam int ICW = 11;
    localparam logic [ICW-1:0] INIT_NOP_END = ICW'(INITCYC);
    localparam logic [ICW-1:0] INIT_REF_END = ICW'(INITCYC + 8);
    localparam logic [7:0]     DIV_LAST     = 8'(REFDIV - 1);

    state_t          state_q, state_d;
    logic [ICW-1:0]  init_cnt_q, init_cnt_d;
    logic [7:0]      div_q, div_d;
    logic [2:0]      pend_q, pend_d;
    logic            ovf_q, ovf_d;
    logic [21:0]     ra_q, ra_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [7:0]      rwd_q, rwd_d;
    logic [7:0]      rdd_q, rdd_d;
    logic            rdv_q, rdv_d;
    logic            ready_q, ready_d;
    logic            tick;
    logic            issue_ref;

    always_ff @(posedge PHI2 or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            div_q      <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
            ra_q       <= '0;
            cmd_q      <= CMD_NOP;
            rwd_q      <= '0;
            rdd_q      <= '0;
            rdv_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            ra_q       <= ra_d;
            cmd_q      <= cmd_d;
            rwd_q      <= rwd_d;
            rdd_q      <= rdd_d;
            rdv_q      <= rdv_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q;
        ra_d       = ra_q;
        cmd_d      = CMD_NOP;
        rwd_d      = rwd_q;
        tick       = 1'b0;
        issue_ref  = 1'b0;
        ready_d    = ready_q;
        // Read data is taken the edge after READ was presented to the RAM.
        rdv_d      = (cmd_q == CMD_READ);
        rdd_d      = (cmd_q == CMD_READ) ? RDQ : rdd_q;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q < INIT_NOP_END) begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end else if (init_cnt_q < INIT_REF_END) begin
                    init_cnt_d = init_cnt_q + 1'b1;
                    cmd_d      = CMD_REF;
                end else begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                tick      = (div_q == DIV_LAST);
                div_d     = tick ? 8'd0 : div_q + 8'd1;
                issue_ref = !RamSEL && (pend_q != 3'd0);

                if (RamSEL) begin
                    ra_d  = {Block, Window, A};
                    cmd_d = nWE ? CMD_READ : CMD_WRITE;
                    if (!nWE) rwd_d = WRD;
                end else if (issue_ref) begin
                    cmd_d = CMD_REF;
                end

                // Tick plus issued refresh cancel out; overflow only when the tick is lost.
                case ({tick, issue_ref})
                    2'b10: begin
                        if (pend_q == 3'd7) ovf_d  = 1'b1;
                        else                pend_d = pend_q + 3'd1;
                    end
                    2'b01:   pend_d = pend_q - 3'd1;
                    default: pend_d = pend_q;
                endcase
            end
        endcase
    end

    assign RA     = ra_q;
    assign RCMD   = cmd_q;
    assign RWD    = rwd_q;
    assign RDD    = rdd_q;
    assign RDV    = rdv_q;
    assign Ready  = ready_q;
    assign RefOvf = ovf_q;

endmodule

// File: tb/tb_geo_ram_seq.sv
// Bench for geo_ram_seq: vector table, hand-built refresh/reset sequences and
// random traffic, all compared against a cycle-level behavioural model.
module tb_geo_ram_seq;

    localparam int INITCYC = 100;
    localparam int REFDIV  = 15;

    logic        PHI2 = 1'b0;
    logic        nRESET = 1'b1;
    logic        RamSEL = 1'b0;
    logic        nWE = 1'b1;
    logic [7:0]  A = '0, WRD = '0, Block = '0, RDQ = '0;
    logic [5:0]  Window = '0;
    logic [21:0] RA;
    logic [1:0]  RCMD;
    logic [7:0]  RWD, RDD;
    logic        RDV, Ready, RefOvf;

    geo_ram_seq #(.REFDIV(REFDIV), .INITCYC(INITCYC)) dut (
        .PHI2(PHI2), .nRESET(nRESET), .RamSEL(RamSEL), .nWE(nWE), .A(A),
        .WRD(WRD), .Block(Block), .Window(Window), .RDQ(RDQ), .RA(RA),
        .RCMD(RCMD), .RWD(RWD), .RDD(RDD), .RDV(RDV), .Ready(Ready),
        .RefOvf(RefOvf)
    );

    always #5 PHI2 = ~PHI2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_run;
    int          m_k, m_runedges, m_pend;
    bit          m_ovf, m_ready, m_rdv;
    logic [21:0] m_ra;
    logic [1:0]  m_cmd;
    logic [7:0]  m_rwd, m_rdd;

    typedef struct {
        logic        sel;
        logic        nwe;
        logic [7:0]  a;
        logic [7:0]  wrd;
        logic [7:0]  blk;
        logic [5:0]  win;
        logic [7:0]  rdq;
        logic [1:0]  e_cmd;
        logic [21:0] e_ra;
        logic [7:0]  e_rwd;
        logic        e_rdv;
        logic [7:0]  e_rdd;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_k = 0; m_runedges = 0; m_pend = 0;
        m_ovf = 0; m_ready = 0; m_rdv = 0;
        m_ra = '0; m_cmd = '0; m_rwd = '0; m_rdd = '0;
    endtask

    // One PHI2 cycle: predict from current inputs, clock, then compare everything.
    task automatic cycle();
        bit tick, refr;
        logic [1:0] prev;
        prev = m_cmd;
        if (!m_run) begin
            if (m_k < INITCYC)          m_cmd = 2'b00;
            else if (m_k < INITCYC + 8) m_cmd = 2'b11;
            else begin m_cmd = 2'b00; m_run = 1; m_ready = 1; end
            m_k++;
        end else begin
            m_runedges++;
            tick = (m_runedges % REFDIV) == 0;
            refr = !RamSEL && (m_pend > 0);
            if (RamSEL) begin
                m_ra  = {Block, Window, A};
                m_cmd = nWE ? 2'b01 : 2'b10;
                if (!nWE) m_rwd = WRD;
            end else if (refr) begin
                m_cmd = 2'b11;
                m_pend--;
            end else begin
                m_cmd = 2'b00;
            end
            if (tick) begin
                if (refr)           m_pend++;
                else if (m_pend == 7) m_ovf = 1;
                else                m_pend++;
            end
        end
        m_rdv = (prev == 2'b01);
        if (m_rdv) m_rdd = RDQ;
        @(posedge PHI2);
        #1;
        chk("rcmd",  RCMD,   m_cmd);
        chk("ra",    RA,     m_ra);
        chk("rwd",   RWD,    m_rwd);
        chk("rdv",   RDV,    m_rdv);
        chk("rdd",   RDD,    m_rdd);
        chk("ready", Ready,  m_ready);
        chk("refovf", RefOvf, m_ovf);
    endtask

    task automatic do_reset();
        #2 nRESET = 1'b0;
        #1;
        chk("rst_ra", RA, 0);
        chk("rst_rcmd", RCMD, 0);
        chk("rst_rwd", RWD, 0);
        chk("rst_rdd", RDD, 0);
        chk("rst_rdv", RDV, 0);
        chk("rst_ready", Ready, 0);
        chk("rst_refovf", RefOvf, 0);
        model_reset();
        RamSEL = 1'b0;
        nWE = 1'b1;
        repeat (2) @(posedge PHI2);
        #2 nRESET = 1'b1;
    endtask

    // Full init with random RamSEL pulses that must be ignored.
    task automatic run_init();
        int n_ref, n_rw, first_ref;
        n_ref = 0; n_rw = 0; first_ref = -1;
        for (int k = 1; k <= INITCYC + 9; k++) begin
            RamSEL = $urandom_range(0, 1) == 1;
            nWE    = $urandom_range(0, 1) == 1;
            A = 8'($urandom); WRD = 8'($urandom); Block = 8'($urandom);
            Window = 6'($urandom); RDQ = 8'($urandom);
            cycle();
            if (RCMD == 2'b11) begin
                n_ref++;
                if (first_ref < 0) first_ref = k;
            end
            if (RCMD == 2'b01 || RCMD == 2'b10) n_rw++;
        end
        RamSEL = 1'b0;
        chk("init_ref_count", n_ref, 8);
        chk("init_first_ref", first_ref, INITCYC + 1);
        chk("init_no_rw", n_rw, 0);
        chk("init_ready", Ready, 1);
        $display("init done: refreshes=%0d first_at=%0d ready=%0b", n_ref, first_ref, Ready);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b0, 8'h3F, 8'h5A, 8'hA5, 6'h2C, 8'h00, 2'b10, 22'h296C3F, 8'h5A, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 8'h10, 8'h00, 8'h01, 6'h02, 8'h00, 2'b01, 22'h004210, 8'h5A, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 6'h00, 8'hC3, 2'b00, 22'h004210, 8'h5A, 1'b1, 8'hC3};
        vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 6'h3F, 8'h11, 2'b01, 22'h3FFFFF, 8'h5A, 1'b0, 8'hC3};
        vecs[4] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 6'h00, 8'h77, 2'b01, 22'h000000, 8'h5A, 1'b1, 8'h77};
        vecs[5] = '{1'b1, 1'b0, 8'h01, 8'hE7, 8'h80, 6'h01, 8'h99, 2'b10, 22'h200101, 8'hE7, 1'b1, 8'h99};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 6'h00, 8'h55, 2'b00, 22'h200101, 8'hE7, 1'b0, 8'h99};

        model_reset();
        do_reset();
        run_init();

        for (int i = 0; i < 7; i++) begin
            RamSEL = vecs[i].sel; nWE = vecs[i].nwe; A = vecs[i].a; WRD = vecs[i].wrd;
            Block = vecs[i].blk; Window = vecs[i].win; RDQ = vecs[i].rdq;
            cycle();
            chk("vec_rcmd", RCMD, vecs[i].e_cmd);
            chk("vec_ra", RA, vecs[i].e_ra);
            chk("vec_rwd", RWD, vecs[i].e_rwd);
            chk("vec_rdv", RDV, vecs[i].e_rdv);
            chk("vec_rdd", RDD, vecs[i].e_rdd);
            $display("vec %0d sel=%0b nwe=%0b ra=%06h rcmd=%0d rwd=%02h rdv=%0b rdd=%02h",
                     i, vecs[i].sel, vecs[i].nwe, RA, RCMD, RWD, RDV, RDD);
        end

        // Reset in the middle of the init refresh burst.
        do_reset();
        repeat (INITCYC + 4) cycle();
        chk("midburst_rcmd", RCMD, 2'b11);
        do_reset();
        run_init();

        // Continuous accesses: pending saturates, eighth tick overflows, then 7 refreshes.
        for (int i = 1; i <= 120; i++) begin
            RamSEL = 1'b1; nWE = $urandom_range(0, 1) == 1;
            A = 8'($urandom); WRD = 8'($urandom); RDQ = 8'($urandom);
            cycle();
            if (i == 119) chk("ovf_before_tick8", RefOvf, 0);
        end
        chk("ovf_at_tick8", RefOvf, 1);
        RamSEL = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (RCMD == 2'b11 && n == i - 1) n++;
        end
        chk("drain_refresh_run", n, 7);
        $display("saturation: refovf=%0b consecutive_refresh=%0d", RefOvf, n);

        // pending=1 with a tick on a free cycle: refresh issued, pending stays 1.
        do_reset();
        run_init();
        for (int i = 1; i <= 29; i++) begin
            RamSEL = 1'b1; nWE = 1'b1; cycle();
        end
        RamSEL = 1'b0;
        cycle(); chk("tick_refresh", RCMD, 2'b11);
        cycle(); chk("tick_refresh_kept", RCMD, 2'b11);
        cycle(); chk("tick_refresh_done", RCMD, 2'b00);
        chk("tick_no_ovf", RefOvf, 0);
        $display("tick+refresh: last rcmd=%0d refovf=%0b", RCMD, RefOvf);

        // Reset between READ issue and data return: no RDV afterwards.
        RamSEL = 1'b1; nWE = 1'b1; A = 8'h42; RDQ = 8'hAA;
        cycle();
        chk("midread_rcmd", RCMD, 2'b01);
        do_reset();
        cycle(); chk("midread_no_rdv", RDV, 0);
        cycle(); chk("midread_no_rdv2", RDV, 0);
        model_reset();
        do_reset();
        run_init();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            RamSEL = $urandom_range(0, 9) < 7;
            nWE    = $urandom_range(0, 1) == 1;
            A = 8'($urandom); WRD = 8'($urandom); Block = 8'($urandom);
            Window = 6'($urandom); RDQ = 8'($urandom);
            cycle();
        end
        $display("random: done refovf=%0b", RefOvf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
